deinterleaver: RTL and testbench



---
 rtl/codec_pkg.sv | 23 ++
 rtl/sdp_ram.sv | 38 +++
 rtl/deinterleaver.sv | 144 ++++++++++++++
 tb/tb_deinterleaver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared definitions for the symbol-stream codec chain.
//   DEF_ROWS / DEF_COLS : default interleaver matrix geometry
//   rd_state_t          : read-side state encoding for frame buffers
//   itl_index()         : original symbol index held at interleaved position k
package codec_pkg;

  localparam int unsigned DEF_ROWS = 4;
  localparam int unsigned DEF_COLS = 8;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Row-major write / column-major read: position k carries original index
  // (k mod rows)*cols + k div rows.
  function automatic int unsigned itl_index(input int unsigned k,
                                            input int unsigned rows,
                                            input int unsigned cols);
    return (k % rows) * cols + k / rows;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// single cycle of latency. The read data register has a synchronous reset
// (maps onto the BRAM output-register reset); the array itself is not reset.
//   clk   : clock
//   rst   : synchronous active-high reset of the read data register
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable
//   raddr : read address
//   rdata : registered read data
module sdp_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/deinterleaver.sv
// Block deinterleaver: inverse of the row/column block interleaver.
// Interleaved ROWS*COLS-symbol frames are written into one bank of a
// ping-pong buffer at their original positions while the other bank is read
// out in linear order.
//   i_clk  : clock
//   i_rst  : synchronous reset, active-high
//   i_data : interleaved input symbol (sampled when i_dv=1)
//   i_dv   : input symbol valid, at most one per cycle, no backpressure
//   o_data : deinterleaved output symbol
//   o_dv   : output symbol valid, N consecutive cycles per frame
//   o_sof  : marks the first output symbol of each frame
module deinterleaver
  import codec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_dv,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_dv,
  output logic                  o_sof
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  // Bank select is the address MSB, so each bank spans 2**AW words
  // (exactly N when N is a power of two).
  localparam int unsigned DEPTH = 2 * (2 ** AW);

  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [AW-1:0] wr_addr;
  logic          wr_sel;
  logic [1:0]    full;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  rd_state_t     state;

  logic          row_wrap;
  logic          wr_last;
  logic          rd_en;
  logic          rd_last;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  always_comb begin
    row_wrap = (wr_row == RW'(ROWS - 1));
    wr_last  = i_dv && row_wrap && (wr_col == CW'(COLS - 1));
    // The first read of a frame is issued in IDLE in the same cycle the full
    // flag is seen, which keeps the post-frame latency at two cycles.
    rd_en    = (state == RD_READ) || full[rd_sel];
    rd_last  = rd_en && (rd_addr == AW'(N - 1));
    full_set = '0;
    full_clr = '0;
    if (wr_last) full_set[wr_sel] = 1'b1;
    if (rd_last) full_clr[rd_sel] = 1'b1;
  end

  // Write address = row*COLS + col, built incrementally without a multiplier.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_row  <= '0;
      wr_col  <= '0;
      wr_addr <= '0;
      wr_sel  <= 1'b0;
    end else if (i_dv) begin
      if (row_wrap) begin
        wr_row <= '0;
        if (wr_col == CW'(COLS - 1)) begin
          wr_col  <= '0;
          wr_addr <= '0;
          wr_sel  <= ~wr_sel;
        end else begin
          wr_col  <= wr_col + CW'(1);
          wr_addr <= AW'(wr_col) + AW'(1);
        end
      end else begin
        wr_row  <= wr_row + RW'(1);
        wr_addr <= wr_addr + AW'(COLS);
      end
    end
  end

  // Set and clear always target different banks, so both apply together.
  always_ff @(posedge i_clk) begin
    if (i_rst) full <= '0;
    else       full <= (full & ~full_clr) | full_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= RD_IDLE;
      rd_sel  <= 1'b0;
      rd_addr <= '0;
    end else if (rd_en) begin
      if (rd_last) begin
        rd_addr <= '0;
        rd_sel  <= ~rd_sel;
        state   <= full[~rd_sel] ? RD_READ : RD_IDLE;
      end else begin
        rd_addr <= rd_addr + AW'(1);
        state   <= RD_READ;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dv  <= 1'b0;
      o_sof <= 1'b0;
    end else begin
      o_dv  <= rd_en;
      o_sof <= rd_en && (rd_addr == '0);
    end
  end

  sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (i_dv),
    .waddr ({wr_sel, wr_addr}),
    .wdata (i_data),
    .re    (rd_en),
    .raddr ({rd_sel, rd_addr}),
    .rdata (o_data)
  );

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    i_dv |-> !full[wr_sel]);

  a_wr_map: assert property (@(posedge i_clk) disable iff (i_rst)
    i_dv |-> (32'(wr_addr) ==
              itl_index(32'(wr_col) * ROWS + 32'(wr_row), ROWS, COLS)));

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver: a 4x8 instance (a) and a 1x8 identity
// instance (b). Outputs are sampled 1 time unit after each rising edge; the
// sample taken after edge s shows the outputs of cycle s+1, so "o_dv two
// cycles after the last input" appears as a step difference of 1.
module tb_deinterleaver;
  import codec_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_di, b_di, a_do, b_do;
  logic       a_dv, b_dv, a_ov, b_ov, a_sof, b_sof;

  deinterleaver #(.DATA_WIDTH(8), .ROWS(4), .COLS(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_data(a_di), .i_dv(a_dv),
    .o_data(a_do), .o_dv(a_ov), .o_sof(a_sof)
  );

  deinterleaver #(.DATA_WIDTH(8), .ROWS(1), .COLS(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_data(b_di), .i_dv(b_dv),
    .o_data(b_do), .o_dv(b_ov), .o_sof(b_sof)
  );

  int n_vec = 0;
  int n_err = 0;
  int step_n = 0;
  logic [7:0] qa[$], qb[$];
  logic       sa[$], sb[$];
  logic [7:0] src[1024];
  int run_a = 0, last_run_a = 0, first_a = -1, last_in_a = 0;
  int run_b = 0, last_run_b = 0, first_b = -1, last_in_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    if (a_ov) begin
      if (first_a < 0) first_a = step_n;
      run_a++;
      if (qa.size() == 0) chk("a_extra_dv", a_ov, 0);
      else begin
        chk("a_data", a_do, qa.pop_front());
        chk("a_sof", a_sof, sa.pop_front());
      end
    end else begin
      if (run_a != 0) last_run_a = run_a;
      run_a = 0;
    end
    if (b_ov) begin
      if (first_b < 0) first_b = step_n;
      run_b++;
      if (qb.size() == 0) chk("b_extra_dv", b_ov, 0);
      else begin
        chk("b_data", b_do, qb.pop_front());
        chk("b_sof", b_sof, sb.pop_front());
      end
    end else begin
      if (run_b != 0) last_run_b = run_b;
      run_b = 0;
    end
  endtask

  task automatic step(input logic adv, input logic [7:0] ad,
                      input logic bdv, input logic [7:0] bd);
    a_dv = adv; a_di = ad; b_dv = bdv; b_di = bd;
    @(posedge clk);
    #1;
    step_n++;
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h5A, 1'b0, 8'h5A);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_dv"}, a_ov, 0);
    chk({tag, "_a_sof"}, a_sof, 0);
    chk({tag, "_a_data"}, a_do, 0);
    chk({tag, "_b_dv"}, b_ov, 0);
    chk({tag, "_b_data"}, b_do, 0);
  endtask

  task automatic start_a();
    first_a = -1;
    last_run_a = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;

    // Single frame: input positions carry 0,8,16,24,1,9,...
    start_a();
    for (int i = 0; i < 32; i++) begin qa.push_back(8'(i)); sa.push_back(i == 0); end
    for (int k = 0; k < 32; k++) step(1'b1, 8'(itl_index(k, 4, 8)), 1'b0, 8'h00);
    last_in_a = step_n;
    idle(40);
    chk("t1_latency", first_a - last_in_a, 1);
    chk("t1_burst", last_run_a, 32);
    chk("t1_drained", qa.size(), 0);

    // Three back-to-back frames, continuous input
    start_a();
    for (int i = 0; i < 96; i++) begin qa.push_back(8'(i)); sa.push_back(i % 32 == 0); end
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 32; k++) step(1'b1, 8'(32 * f + itl_index(k, 4, 8)), 1'b0, 8'h00);
      if (f == 0) last_in_a = step_n;
    end
    idle(40);
    chk("t2_latency", first_a - last_in_a, 1);
    chk("t2_burst", last_run_a, 96);
    chk("t2_drained", qa.size(), 0);

    // Gapped input: valid every other cycle
    start_a();
    for (int i = 0; i < 32; i++) begin qa.push_back(8'(i)); sa.push_back(i == 0); end
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 8'(itl_index(k, 4, 8)), 1'b0, 8'h00);
      last_in_a = step_n;
      step(1'b0, 8'hA5, 1'b0, 8'h00);
    end
    idle(40);
    chk("t3_latency", first_a - last_in_a, 1);
    chk("t3_burst", last_run_a, 32);
    chk("t3_drained", qa.size(), 0);

    // Reset after 20 symbols of a frame, then a fresh frame
    for (int k = 0; k < 20; k++) step(1'b1, 8'(200 + k), 1'b0, 8'h00);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk_zero("t4_in_reset");
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 8'h00);
    chk_zero("t4_post_reset");
    start_a();
    for (int i = 0; i < 32; i++) begin
      src[i] = 8'(i * 7 + 3);
      qa.push_back(src[i]);
      sa.push_back(i == 0);
    end
    for (int k = 0; k < 32; k++) step(1'b1, src[itl_index(k, 4, 8)], 1'b0, 8'h00);
    last_in_a = step_n;
    idle(40);
    chk("t4_latency", first_a - last_in_a, 1);
    chk("t4_burst", last_run_a, 32);
    chk("t4_drained", qa.size(), 0);

    // Random symbols through the reference interleaving, 32 frames
    start_a();
    for (int i = 0; i < 1024; i++) begin
      src[i] = 8'($urandom);
      qa.push_back(src[i]);
      sa.push_back(i % 32 == 0);
    end
    for (int f = 0; f < 32; f++)
      for (int k = 0; k < 32; k++)
        step(1'b1, src[32 * f + itl_index(k, 4, 8)], 1'b0, 8'h00);
    idle(40);
    chk("t5_burst", last_run_a, 1024);
    chk("t5_drained", qa.size(), 0);

    // ROWS=1 instance is an identity mapping
    first_b = -1;
    last_run_b = 0;
    for (int i = 0; i < 8; i++) begin qb.push_back(8'(i)); sb.push_back(i == 0); end
    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1, 8'(k));
    last_in_b = step_n;
    idle(12);
    chk("t6_latency", first_b - last_in_b, 1);
    chk("t6_burst", last_run_b, 8);
    chk("t6_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
